sd_cmd_bus_if: RTL and testbench

Bus-side front end of the command path. A Wishbone B4 classic slave owns the SDIO_ARG and SDIO_CMD registers that drive `sd_cmd_adapter`. It keeps sticky copies of the command status events, clear and mask registers, and an interrupt. Reads of response registers are forwarded through the adapter's `adr_in`/`rd_wb`/`ack_cpsm` handshake.

---
 rtl/sd_cmd_bus_if_pkg.sv | 48 ++++
 rtl/sd_cmd_bus_if_if.sv | 23 ++
 rtl/sd_edge_sticky.sv | 32 +++
 rtl/sd_cmd_bus_if.sv | 164 ++++++++++++++++
 tb/tb_sd_cmd_bus_if.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_cmd_bus_if_pkg.sv
// rtl/sd_cmd_bus_if_pkg.sv - register map, status bit positions and bus FSM states
package sd_cmd_bus_if_pkg;

    localparam logic [6:0] ADR_ARG     = 7'h08;
    localparam logic [6:0] ADR_CMD     = 7'h0C;
    localparam logic [6:0] ADR_RESPCMD = 7'h10;
    localparam logic [6:0] ADR_RESP1   = 7'h14;
    localparam logic [6:0] ADR_RESP2   = 7'h18;
    localparam logic [6:0] ADR_RESP3   = 7'h1C;
    localparam logic [6:0] ADR_RESP4   = 7'h20;
    localparam logic [6:0] ADR_STA     = 7'h34;
    localparam logic [6:0] ADR_ICR     = 7'h38;
    localparam logic [6:0] ADR_MASK    = 7'h3C;

    localparam int STA_CCRCFAIL   = 0;
    localparam int STA_CTIMEOUT   = 2;
    localparam int STA_CMDREND    = 6;
    localparam int STA_CMDSENT    = 7;
    localparam int STA_CMDACT     = 11;
    localparam int STA_CMDBUSYERR = 31;

    localparam int CMD_CPSMEN   = 10;
    localparam int CMD_LONGRSP  = 7;
    localparam int CMD_WAITRESP = 6;

    // Writable CMD bits: CPSMEN, long/wait response and the 6-bit index
    localparam logic [31:0] CMD_WMASK = 32'h0000_04FF;

    // Status events that end an issued command
    localparam logic [31:0] DONE_MASK = (32'd1 << STA_CCRCFAIL) | (32'd1 << STA_CTIMEOUT) |
                                        (32'd1 << STA_CMDREND)  | (32'd1 << STA_CMDSENT);

    localparam logic [31:0] STICKY_MASK = DONE_MASK | (32'd1 << STA_CMDBUSYERR);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LACK,
        ST_FREQ,
        ST_FWAIT,
        ST_FDONE
    } bus_state_e;

    function automatic logic is_fwd_adr(input logic [6:0] adr);
        return (adr == ADR_RESPCMD) || (adr == ADR_RESP1) || (adr == ADR_RESP2) ||
               (adr == ADR_RESP3)   || (adr == ADR_RESP4);
    endfunction

endpackage

// File: rtl/sd_cmd_bus_if_if.sv
// rtl/sd_cmd_bus_if_if.sv - Wishbone classic bus bundle with master/slave views
interface sd_cmd_bus_if_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [6:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/sd_edge_sticky.sv
// rtl/sd_edge_sticky.sv - per-bit rising-edge detect feeding sticky flags, set beats clear
module sd_edge_sticky
    import sd_cmd_bus_if_pkg::*;
#(
    parameter int             W      = 32,
    parameter logic [W-1:0]   STICKY = W'(STICKY_MASK)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic [W-1:0] set,
    input  logic [W-1:0] clr,
    output logic [W-1:0] rise,
    output logic [W-1:0] flags
);

    logic [W-1:0] prev;

    assign rise = din & ~prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= '0;
            flags <= '0;
        end else begin
            prev  <= din;
            // Clear first, then OR in new events so a same-cycle event survives
            flags <= ((flags & ~clr) | rise | set) & STICKY;
        end
    end

endmodule

// File: rtl/sd_cmd_bus_if.sv
// rtl/sd_cmd_bus_if.sv - Wishbone register front end for the SD command path
module sd_cmd_bus_if
    import sd_cmd_bus_if_pkg::*;
#(
    parameter int FWD_TIMEOUT = 16
) (
    input  logic           sd_clk,
    input  logic           rst,
    sd_cmd_bus_if_if.slave wb,
    output logic [31:0]    sd_cmd,
    output logic [31:0]    sd_arg,
    input  logic [31:0]    sd_status,
    output logic [6:0]     adr_in,
    output logic           rd_wb,
    input  logic [31:0]    sd_reg,
    input  logic           ack_cpsm,
    output logic           irq_o
);

    localparam int CW = $clog2(FWD_TIMEOUT + 1);

    bus_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack_d, err_d, rd_wb_d, capture;
    logic [6:0]    adr_d;

    logic [31:0] mask_q;
    logic        pending;
    logic        done_q;
    logic [31:0] rise, sta_flags, sta_view, icr_clr, rd_local;
    logic        wr_fire, cmd_wr, arg_wr, cmd_drop, arg_drop, busy_err;

    sd_edge_sticky #(.W(32), .STICKY(STICKY_MASK)) u_sticky (
        .clk   (sd_clk),
        .rst   (rst),
        .din   (sd_status),
        .set   ({busy_err, 31'b0}),
        .clr   (icr_clr),
        .rise  (rise),
        .flags (sta_flags)
    );

    // Register side effects land on the LACK edge, together with the ack
    assign wr_fire  = (state_q == ST_LACK) && wb.wb_cyc_i && wb.wb_stb_i && wb.wb_we_i;
    assign cmd_wr   = wr_fire && (wb.wb_adr_i == ADR_CMD);
    assign arg_wr   = wr_fire && (wb.wb_adr_i == ADR_ARG);
    assign cmd_drop = cmd_wr && (pending || (wb.wb_dat_i[CMD_CPSMEN] && sd_status[STA_CMDACT]));
    assign arg_drop = arg_wr && pending;
    assign busy_err = cmd_drop || arg_drop;
    assign icr_clr  = (wr_fire && (wb.wb_adr_i == ADR_ICR)) ? wb.wb_dat_i : 32'd0;

    always_comb begin
        sta_view             = sta_flags;
        sta_view[STA_CMDACT] = sd_status[STA_CMDACT];
    end

    always_comb begin
        rd_local = 32'd0;
        case (wb.wb_adr_i)
            ADR_ARG:  rd_local = sd_arg;
            ADR_CMD:  rd_local = sd_cmd;
            ADR_STA:  rd_local = sta_view;
            ADR_MASK: rd_local = mask_q;
            default:  rd_local = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_wb_d = rd_wb;
        adr_d   = adr_in;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A strobe still held right after a termination belongs to the finished cycle
                if (wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_ack_o && !wb.wb_err_o) begin
                    if (!wb.wb_we_i && is_fwd_adr(wb.wb_adr_i)) state_d = ST_FREQ;
                    else                                         state_d = ST_LACK;
                end
            end
            ST_LACK: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FREQ: begin
                adr_d   = wb.wb_adr_i;
                rd_wb_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_FWAIT;
            end
            ST_FWAIT: begin
                if (ack_cpsm) begin
                    rd_wb_d = 1'b0;
                    capture = 1'b1;
                    state_d = ST_FDONE;
                end else if (cnt_q == CW'(FWD_TIMEOUT - 1)) begin
                    rd_wb_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FDONE: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            wb.wb_dat_o <= 32'd0;
            rd_wb       <= 1'b0;
            adr_in      <= 7'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb.wb_ack_o <= ack_d;
            wb.wb_err_o <= err_d;
            rd_wb       <= rd_wb_d;
            adr_in      <= adr_d;
            if (capture)
                wb.wb_dat_o <= sd_reg;
            else if (state_q == ST_LACK && !wb.wb_we_i)
                wb.wb_dat_o <= rd_local;
        end
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            sd_cmd  <= 32'd0;
            sd_arg  <= 32'd0;
            mask_q  <= 32'd0;
            pending <= 1'b0;
            done_q  <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            done_q <= pending && |(rise & DONE_MASK);
            irq_o  <= |(sta_view & mask_q);
            if (arg_wr && !arg_drop)
                sd_arg <= wb.wb_dat_i;
            if (wr_fire && (wb.wb_adr_i == ADR_MASK))
                mask_q <= wb.wb_dat_i;
            // Dropping CPSMEN once the command ends keeps the adapter from re-issuing it
            if (done_q) begin
                sd_cmd[CMD_CPSMEN] <= 1'b0;
                pending            <= 1'b0;
            end else if (cmd_wr && !cmd_drop) begin
                sd_cmd  <= wb.wb_dat_i & CMD_WMASK;
                pending <= wb.wb_dat_i[CMD_CPSMEN];
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_bus_if.sv
// tb/tb_sd_cmd_bus_if.sv - directed self-checking bench for sd_cmd_bus_if
module tb_sd_cmd_bus_if;
    import sd_cmd_bus_if_pkg::*;

    logic        sd_clk = 1'b0;
    logic        rst;
    logic [31:0] sd_cmd, sd_arg, sd_status, sd_reg;
    logic [6:0]  adr_in;
    logic        rd_wb, ack_cpsm, irq_o;

    always #5 sd_clk = ~sd_clk;

    sd_cmd_bus_if_if wb();

    sd_cmd_bus_if #(.FWD_TIMEOUT(16)) dut (
        .sd_clk    (sd_clk),
        .rst       (rst),
        .wb        (wb),
        .sd_cmd    (sd_cmd),
        .sd_arg    (sd_arg),
        .sd_status (sd_status),
        .adr_in    (adr_in),
        .rd_wb     (rd_wb),
        .sd_reg    (sd_reg),
        .ack_cpsm  (ack_cpsm),
        .irq_o     (irq_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    always @(posedge sd_clk) cyc_no <= cyc_no + 1;

    // Adapter model: acks a forwarded read once rd_wb has been seen model_delay+1 times
    int          model_delay;
    logic [31:0] model_data;
    int          rd_cnt, rd_len, rd_rise_at, cpsm_at;
    logic        rd_ever;

    initial begin
        ack_cpsm = 1'b0; sd_reg = 32'd0;
        rd_cnt = 0; rd_len = 0; rd_rise_at = 0; cpsm_at = 0; rd_ever = 1'b0;
        forever begin
            @(posedge sd_clk); #1;
            ack_cpsm = 1'b0;
            if (rd_wb === 1'b1) begin
                rd_cnt++;
                rd_ever = 1'b1;
                if (rd_cnt == 1) rd_rise_at = cyc_no;
                if (model_delay >= 0 && rd_cnt == model_delay + 1) begin
                    ack_cpsm = 1'b1;
                    sd_reg   = model_data;
                    cpsm_at  = cyc_no;
                end
            end else begin
                if (rd_cnt != 0) rd_len = rd_cnt;
                rd_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                        output logic [31:0] rdat, output logic acked, output logic erred,
                        output int done_at, output int lat);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = adr;  wb.wb_dat_i = dat;
        rdat = 32'd0; acked = 1'b0; erred = 1'b0; done_at = 0; lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge sd_clk); #1;
            if (wb.wb_ack_o || wb.wb_err_o) begin
                acked = wb.wb_ack_o; erred = wb.wb_err_o;
                rdat = wb.wb_dat_o; done_at = cyc_no; lat = i;
                break;
            end
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        @(posedge sd_clk); #1;
    endtask

    task automatic wr(input string tag, input logic [6:0] adr, input logic [31:0] dat);
        logic [31:0] r; logic a, e; int t, l;
        xfer(1'b1, adr, dat, r, a, e, t, l);
        check({tag, " ack"}, {31'd0, a}, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [6:0] adr, input logic [31:0] exp);
        logic [31:0] r; logic a, e; int t, l;
        xfer(1'b0, adr, 32'd0, r, a, e, t, l);
        check({tag, " ack"}, {31'd0, a}, 32'd1);
        check(tag, r, exp);
    endtask

    logic [31:0] rdat;
    logic        acked, erred, seen;
    int          done_at, lat;

    initial begin
        rst = 1'b1; sd_status = 32'd0; model_delay = -1; model_data = 32'd0;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = 7'd0; wb.wb_dat_i = 32'd0;
        repeat (3) @(posedge sd_clk);
        #1 rst = 1'b0;

        check("reset sd_cmd", sd_cmd, 32'd0);
        check("reset sd_arg", sd_arg, 32'd0);
        check("reset irq_o", {31'd0, irq_o}, 32'd0);
        check("reset rd_wb", {31'd0, rd_wb}, 32'd0);
        check("reset adr_in", {25'd0, adr_in}, 32'd0);
        check("reset ack", {31'd0, wb.wb_ack_o}, 32'd0);
        check("reset err", {31'd0, wb.wb_err_o}, 32'd0);

        xfer(1'b0, ADR_STA, 32'd0, rdat, acked, erred, done_at, lat);
        check("reset STA", rdat, 32'd0);
        check("local ack latency", lat, 2);
        rd("reset CMD", ADR_CMD, 32'd0);
        rd("reset MASK", ADR_MASK, 32'd0);
        check("rd_wb stayed low", {31'd0, rd_ever}, 32'd0);

        wr("ARG write", ADR_ARG, 32'h2345_6786);
        wr("CMD write", ADR_CMD, 32'h0000_044F);
        check("sd_cmd issued", sd_cmd, 32'h0000_044F);
        check("sd_arg issued", sd_arg, 32'h2345_6786);
        rd("CMD readback", ADR_CMD, 32'h0000_044F);

        sd_status[STA_CMDSENT] = 1'b1;
        @(posedge sd_clk); #1;
        check("sd_cmd one edge after CMDSENT", sd_cmd, 32'h0000_044F);
        @(posedge sd_clk); #1;
        check("sd_cmd two edges after CMDSENT", sd_cmd, 32'h0000_004F);
        sd_status[STA_CMDSENT] = 1'b0;
        rd("STA CMDSENT", ADR_STA, 32'h0000_0080);

        model_delay = 3; model_data = 32'h0F56_7890;
        xfer(1'b0, ADR_RESP1, 32'd0, rdat, acked, erred, done_at, lat);
        check("RESP1 ack", {31'd0, acked}, 32'd1);
        check("RESP1 data", rdat, 32'h0F56_7890);
        check("RESP1 ack after ack_cpsm", done_at - cpsm_at, 2);
        check("RESP1 rd_wb length", rd_len, 4);
        check("RESP1 adr_in", {25'd0, adr_in}, 32'h0000_0014);

        model_delay = -1;
        xfer(1'b0, ADR_RESP2, 32'd0, rdat, acked, erred, done_at, lat);
        check("RESP2 err", {31'd0, erred}, 32'd1);
        check("RESP2 no ack", {31'd0, acked}, 32'd0);
        check("RESP2 err timing", done_at - rd_rise_at, 16);
        check("RESP2 rd_wb length", rd_len, 16);
        check("RESP2 rd_wb low", {31'd0, rd_wb}, 32'd0);
        rd("idle after err", ADR_MASK, 32'd0);

        sd_status[STA_CMDACT] = 1'b1;
        wr("CMD while CMDACT", ADR_CMD, 32'h0000_044F);
        check("sd_cmd kept while busy", sd_cmd, 32'h0000_004F);
        rd("STA busy error", ADR_STA, 32'h8000_0880);
        wr("ICR busy", ADR_ICR, 32'h8000_0000);
        rd("STA busy cleared", ADR_STA, 32'h0000_0880);
        sd_status[STA_CMDACT] = 1'b0;

        wr("MASK write", ADR_MASK, 32'h0000_0001);
        rd("MASK readback", ADR_MASK, 32'h0000_0001);
        check("irq before CCRCFAIL", {31'd0, irq_o}, 32'd0);
        sd_status[STA_CCRCFAIL] = 1'b1;
        repeat (2) begin @(posedge sd_clk); #1; end
        check("irq after CCRCFAIL", {31'd0, irq_o}, 32'd1);
        rd("STA CCRCFAIL", ADR_STA, 32'h0000_0081);
        sd_status[STA_CCRCFAIL] = 1'b0;
        repeat (2) begin @(posedge sd_clk); #1; end

        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = ADR_ICR; wb.wb_dat_i = 32'h0000_0001;
        @(posedge sd_clk); #1;
        sd_status[STA_CCRCFAIL] = 1'b1;
        @(posedge sd_clk); #1;
        check("ICR collide ack", {31'd0, wb.wb_ack_o}, 32'd1);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        @(posedge sd_clk); #1;
        rd("STA set wins", ADR_STA, 32'h0000_0081);
        check("irq after collide", {31'd0, irq_o}, 32'd1);
        wr("ICR plain", ADR_ICR, 32'h0000_0001);
        rd("STA CCRCFAIL cleared", ADR_STA, 32'h0000_0080);
        check("irq after clear", {31'd0, irq_o}, 32'd0);
        sd_status = 32'd0;

        wr("CMD reissue", ADR_CMD, 32'h0000_044F);
        check("sd_cmd reissued", sd_cmd, 32'h0000_044F);
        wr("ARG while pending", ADR_ARG, 32'h1111_1111);
        check("sd_arg kept while pending", sd_arg, 32'h2345_6786);
        rd("STA pending error", ADR_STA, 32'h8000_0080);

        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = ADR_RESP3; wb.wb_dat_i = 32'd0;
        repeat (4) begin @(posedge sd_clk); #1; end
        check("RESP3 rd_wb high", {31'd0, rd_wb}, 32'd1);
        rst = 1'b1;
        @(posedge sd_clk); #1;
        check("mid reset rd_wb", {31'd0, rd_wb}, 32'd0);
        check("mid reset sd_cmd", sd_cmd, 32'd0);
        check("mid reset sd_arg", sd_arg, 32'd0);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge sd_clk); #1;
            if (wb.wb_ack_o || wb.wb_err_o) seen = 1'b1;
        end
        check("no term after reset", {31'd0, seen}, 32'd0);
        rd("STA after reset", ADR_STA, 32'd0);
        rd("MASK after reset", ADR_MASK, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
